controller_stream_to_ram: RTL

Avalon-ST to on-chip RAM write engine that sits directly upstream of the controller data RAM (2048 x 32, single-cycle write port, no waitrequest). It accepts one packet of 32-bit words from a streaming source (ADC or encoder snapshot path) and writes it into the RAM starting at a programmed word address, wrapping at the top of the RAM. A small FIFO decouples the source from RAM clock-enable stalls. Completion and error status go to the Nios control logic.

---
 rtl/controller_stream_to_ram.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/controller_stream_to_ram.sv
// Packet write engine: takes one Avalon-ST packet of 32-bit words, buffers it
// in a small FIFO and writes it into the controller data RAM from a programmed
// base word address. The address wraps at the top of the RAM.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start, source held off
// WAIT_SOP | ready, dropping beats until a start-of-packet beat arrives
// XFER     | accepting packet words into the FIFO while draining to RAM
// FLUSH    | all expected words taken, dropping the packet tail up to eop
// DONE     | one-cycle completion pulse
module controller_stream_to_ram #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_address,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   input  logic                  snk_valid,
   output logic                  snk_ready,
   input  logic [31:0]           snk_data,
   input  logic                  snk_startofpacket,
   input  logic                  snk_endofpacket,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [3:0]            ram_byteenable,
   output logic [31:0]           ram_writedata,
   input  logic                  ram_clken,
   output logic                  busy,
   output logic                  done,
   output logic                  error_short,
   output logic                  error_long
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0]       PTR_ONE  = 1;
   localparam logic [PW:0]         CNT_ONE  = 1;
   localparam logic [PW:0]         CNT_FULL = (PW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_C    = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_SOP, S_XFER, S_FLUSH, S_DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   acc_cnt;
   logic [ADDR_WIDTH:0]   wr_cnt;
   logic                  discard;
   logic                  error_short_q;
   logic                  error_long_q;

   logic [31:0]           fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [PW:0]           fifo_cnt;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  short_eop;
   logic                  discard_after;
   logic [ADDR_WIDTH:0]   wr_after_pop;
   logic [ADDR_WIDTH:0]   wr_cnt_nxt;

   assign fifo_full  = (fifo_cnt == CNT_FULL);
   assign fifo_empty = (fifo_cnt == '0);

   assign ram_write      = ((state == S_XFER) || (state == S_FLUSH)) && !fifo_empty;
   assign ram_chipselect = ram_write;
   assign ram_byteenable = {4{ram_write}};
   assign ram_address    = ram_write ? addr_q : '0;
   assign ram_writedata  = ram_write ? fifo_mem[rd_ptr] : '0;
   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign error_short    = error_short_q;
   assign error_long     = error_long_q;

   // Source handshake depends only on registered state and FIFO occupancy.
   always_comb begin
      snk_ready = 1'b0;
      case (state)
         S_WAIT_SOP: snk_ready = 1'b1;
         S_XFER:     snk_ready = (acc_cnt != '0) && !fifo_full;
         S_FLUSH:    snk_ready = discard;
         default:    snk_ready = 1'b0;
      endcase
   end

   assign push = snk_valid && snk_ready &&
                 (((state == S_WAIT_SOP) && snk_startofpacket) || (state == S_XFER));
   assign pop  = ram_write && ram_clken;

   // A short packet trims the remaining write count to what was actually accepted.
   assign short_eop     = (state == S_XFER) && push && snk_endofpacket && (acc_cnt > ONE_C);
   assign wr_after_pop  = pop ? (wr_cnt - ONE_C) : wr_cnt;
   assign wr_cnt_nxt    = short_eop ? (wr_after_pop - (acc_cnt - ONE_C)) : wr_after_pop;
   assign discard_after = discard && !(snk_valid && snk_endofpacket);

   // FIFO storage; contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= snk_data;
   end

   // Sequencer, FIFO pointers, address/counters and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         addr_q        <= '0;
         acc_cnt       <= '0;
         wr_cnt        <= '0;
         discard       <= 1'b0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         fifo_cnt      <= '0;
         error_short_q <= 1'b0;
         error_long_q  <= 1'b0;
      end else if (abort) begin
         state    <= S_IDLE;
         discard  <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            addr_q <= addr_q + ADDR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (word_count == '0) begin
                     state <= S_DONE;
                  end else begin
                     state         <= S_WAIT_SOP;
                     error_short_q <= 1'b0;
                     error_long_q  <= 1'b0;
                     addr_q        <= base_address;
                     acc_cnt       <= word_count;
                     wr_cnt        <= word_count;
                     discard       <= 1'b0;
                  end
               end
            end
            S_WAIT_SOP: begin
               if (push) begin
                  acc_cnt <= acc_cnt - ONE_C;
                  state   <= S_XFER;
                  if (snk_endofpacket) begin
                     acc_cnt <= '0;
                     if (acc_cnt > ONE_C) begin
                        error_short_q <= 1'b1;
                        wr_cnt        <= ONE_C;
                     end
                  end else if (acc_cnt == ONE_C) begin
                     state   <= S_FLUSH;
                     discard <= 1'b1;
                  end
               end
            end
            S_XFER: begin
               wr_cnt <= wr_cnt_nxt;
               if (push) begin
                  acc_cnt <= acc_cnt - ONE_C;
                  if (snk_endofpacket) begin
                     acc_cnt <= '0;
                     if (acc_cnt > ONE_C) error_short_q <= 1'b1;
                  end else if (acc_cnt == ONE_C) begin
                     state   <= S_FLUSH;
                     discard <= 1'b1;
                  end
               end
               // A push always leaves at least one word unwritten, so this
               // cannot collide with the move to FLUSH above.
               if (wr_cnt_nxt == '0) state <= S_DONE;
            end
            S_FLUSH: begin
               wr_cnt <= wr_after_pop;
               if (snk_valid && snk_ready) begin
                  error_long_q <= 1'b1;
                  if (snk_endofpacket) discard <= 1'b0;
               end
               if ((wr_after_pop == '0) && !discard_after) state <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
